shift_reg_serializer: RTL and testbench

Parallel-to-serial transmitter feeding the 8-bit universal shift register from its serial end. Accepts parallel words over a valid/ready handshake and emits them one bit per bit-period on `serial_out`. Alongside each bit it drives the matching 2-bit shift `mode` code, so the downstream shift register reassembles the word exactly. A one-entry holding register lets frames run back-to-back with no idle gap.

---
 rtl/shift_reg_pkg.sv | 20 ++
 rtl/bit_period_timer.sv | 31 +++
 rtl/shift_reg_serializer.sv | 106 ++++++++++
 tb/tb_shift_reg_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Definitions shared by the serializer and the universal shift register it feeds:
// the shift mode codes and the serializer FSM state encoding.
package shift_reg_pkg;

  localparam logic [1:0] NO_SHIFT    = 2'b00;
  localparam logic [1:0] LEFT_SHIFT  = 2'b01;
  localparam logic [1:0] RIGHT_SHIFT = 2'b10;
  localparam logic [1:0] LOAD        = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The receiver must shift toward the end that the serializer sends first.
  function automatic logic [1:0] shiftCode(input bit msbFirst);
    return msbFirst ? LEFT_SHIFT : RIGHT_SHIFT;
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Bit-period timer: down-counter that strobes on the last cycle of every
// BIT_DIV-cycle bit period while running; with BIT_DIV=1 it strobes every cycle.
module bit_period_timer #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic restart,
  output logic strobe
);

  localparam int CW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(BIT_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Restart wins so the first bit of a fresh frame always gets a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (restart) begin
      r_cnt <= RELOAD;
    end else if (run) begin
      r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - CW'(1);
    end
  end

  assign strobe = run && (r_cnt == '0);

endmodule

// File: rtl/shift_reg_serializer.sv
// Parallel-to-serial transmitter for the universal shift register: one bit per
// bit period plus the matching shift code, with a one-word holding register.
module shift_reg_serializer
  import shift_reg_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic [1:0]        shift_mode,
  output logic              frame_done,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [1:0] MODE = shiftCode(MSB_FIRST);

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_hold;
  logic              r_holdFull;
  logic [BW-1:0]     r_bitCnt;

  logic w_run;
  logic w_start;
  logic w_strobe;
  logic w_lastBit;

  assign w_run     = (r_state == SHIFT);
  assign w_start   = (r_state == IDLE) && tx_valid;
  assign w_lastBit = w_strobe && (r_bitCnt == LAST_BIT);

  bit_period_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (w_run),
    .restart (w_start),
    .strobe  (w_strobe)
  );

  function automatic logic [DATA_W-1:0] shiftOne(input logic [DATA_W-1:0] v);
    return MSB_FIRST ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
  endfunction

  // On the final strobe a held word beats a word offered in the same cycle;
  // either one continues the stream with no idle gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_shreg    <= '0;
      r_hold     <= '0;
      r_holdFull <= 1'b0;
      r_bitCnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (tx_valid) begin
            r_shreg  <= tx_data;
            r_bitCnt <= '0;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (tx_valid && !r_holdFull && !w_lastBit) begin
            r_hold     <= tx_data;
            r_holdFull <= 1'b1;
          end
          if (w_strobe) begin
            if (w_lastBit) begin
              r_bitCnt <= '0;
              if (r_holdFull) begin
                r_shreg    <= r_hold;
                r_holdFull <= 1'b0;
              end else if (tx_valid) begin
                r_shreg <= tx_data;
              end else begin
                r_shreg <= '0;
                r_state <= IDLE;
              end
            end else begin
              r_shreg  <= shiftOne(r_shreg);
              r_bitCnt <= r_bitCnt + BW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_ready   = !r_holdFull;
  assign busy       = w_run;
  assign serial_out = w_run && (MSB_FIRST ? r_shreg[DATA_W-1] : r_shreg[0]);
  assign shift_mode = w_strobe ? MODE : NO_SHIFT;
  assign frame_done = w_lastBit;

endmodule

// File: tb/tb_shift_reg_serializer.sv
// Scoreboard bench: two serializer configurations, each checked by a model of
// the receiving shift register and a queue of words expected to arrive.
module tb_shift_reg_serializer;

  logic       clk = 1'b0;
  logic       resetN;
  logic       txValid   [2];
  logic [7:0] txData    [2];
  logic       txReady   [2];
  logic       serialOut [2];
  logic [1:0] shiftMode [2];
  logic       frameDone [2];
  logic       busy      [2];

  logic [7:0] expQ0[$];
  logic [7:0] expQ1[$];
  int         nBits [2];
  int         since [2];
  logic [7:0] rxReg [2];
  int         nChecks = 0;
  int         nFails  = 0;

  always #5 clk = ~clk;

  shift_reg_serializer #(.DATA_W(8), .BIT_DIV(1), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .reset_n(resetN), .tx_data(txData[0]), .tx_valid(txValid[0]),
    .tx_ready(txReady[0]), .serial_out(serialOut[0]), .shift_mode(shiftMode[0]),
    .frame_done(frameDone[0]), .busy(busy[0])
  );

  shift_reg_serializer #(.DATA_W(8), .BIT_DIV(3), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset_n(resetN), .tx_data(txData[1]), .tx_valid(txValid[1]),
    .tx_ready(txReady[1]), .serial_out(serialOut[1]), .shift_mode(shiftMode[1]),
    .frame_done(frameDone[1]), .busy(busy[1])
  );

  function automatic int divOf(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] expMode(input int u);
    return (u == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic int qSize(input int u);
    return (u == 0) ? expQ0.size() : expQ1.size();
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer a word from a falling edge; it is expected once a rising edge sees ready.
  task automatic applyStimulus(input int u, input logic [7:0] d);
    bit r;
    int guard;
    guard = 0;
    txValid[u] = 1'b1;
    txData[u]  = d;
    do begin
      r = txReady[u];
      @(negedge clk);
      guard++;
    end while (!r && guard < 2000);
    checkOutput("accept handshake", r, 1'b1);
    if (r) begin
      if (u == 0) expQ0.push_back(d);
      else        expQ1.push_back(d);
    end
    txValid[u] = 1'b0;
    txData[u]  = 8'($urandom);
  endtask

  task automatic waitDrain(input int u);
    int guard;
    guard = 0;
    while ((qSize(u) != 0 || busy[u]) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain pending words", qSize(u), 0);
  endtask

  // Downstream shift register model plus the per-bit timing rules.
  task automatic monitorUnit(input int u);
    logic [7:0] exp;
    if (!resetN) begin
      nBits[u] = 0;
      since[u] = 0;
      rxReg[u] = '0;
      return;
    end
    if (!busy[u]) begin
      checkOutput("idle outputs", {serialOut[u], shiftMode[u], frameDone[u]}, 0);
      since[u] = 0;
    end else begin
      since[u]++;
      if (shiftMode[u] != 2'b00) begin
        checkOutput("strobe mode", shiftMode[u], expMode(u));
        checkOutput("bit period", since[u], divOf(u));
        since[u] = 0;
        if (shiftMode[u] == 2'b01) rxReg[u] = {rxReg[u][6:0], serialOut[u]};
        else                       rxReg[u] = {serialOut[u], rxReg[u][7:1]};
        nBits[u]++;
      end
      if (frameDone[u]) begin
        checkOutput("bits per frame", nBits[u], 8);
        nBits[u] = 0;
        checkOutput("frame pending", qSize(u) > 0, 1'b1);
        if (qSize(u) > 0) begin
          exp = (u == 0) ? expQ0.pop_front() : expQ1.pop_front();
          checkOutput("received word", rxReg[u], exp);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitorUnit(0);
    monitorUnit(1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] w;
    resetN = 1'b0;
    for (int u = 0; u < 2; u++) begin
      txValid[u] = 1'b0;
      txData[u]  = '0;
    end
    #12;
    for (int u = 0; u < 2; u++) begin
      checkOutput("reset ready", txReady[u], 1'b1);
      checkOutput("reset outputs", {serialOut[u], shiftMode[u], frameDone[u], busy[u]}, 0);
    end
    waitNeg(2);
    resetN = 1'b1;
    waitNeg(1);

    $display("[TB] single word 0xA5, MSB first, one cycle per bit");
    w = 8'hA5;
    applyStimulus(0, w);
    for (int k = 0; k < 8; k++) begin
      checkOutput("A5 serial bit", serialOut[0], w[7-k]);
      checkOutput("A5 shift code", shiftMode[0], 2'b01);
      checkOutput("A5 frame_done", frameDone[0], k == 7);
      waitNeg(1);
    end
    checkOutput("A5 idle after frame", busy[0], 1'b0);
    waitDrain(0);

    $display("[TB] single word 0x01, LSB first, three cycles per bit");
    w = 8'h01;
    applyStimulus(1, w);
    for (int c = 1; c <= 24; c++) begin
      checkOutput("01 serial bit", serialOut[1], w[(c-1)/3]);
      checkOutput("01 shift code", shiftMode[1], (c % 3 == 0) ? 2'b10 : 2'b00);
      checkOutput("01 frame_done", frameDone[1], c == 24);
      waitNeg(1);
    end
    checkOutput("01 idle after frame", busy[1], 1'b0);
    waitDrain(1);

    $display("[TB] back-to-back 0x3C then 0xC3");
    applyStimulus(0, 8'h3C);
    applyStimulus(0, 8'hC3);
    checkOutput("b2b ready low after hold", txReady[0], 1'b0);
    waitNeg(6);
    checkOutput("b2b ready low in cycle 8", txReady[0], 1'b0);
    checkOutput("b2b first frame_done", frameDone[0], 1'b1);
    waitNeg(1);
    checkOutput("b2b ready back in cycle 9", txReady[0], 1'b1);
    checkOutput("b2b no gap", busy[0], 1'b1);
    checkOutput("b2b second word bit0", serialOut[0], 1'b1);
    waitNeg(7);
    checkOutput("b2b second frame_done", frameDone[0], 1'b1);
    waitNeg(1);
    checkOutput("b2b idle after", busy[0], 1'b0);
    waitDrain(0);

    $display("[TB] bypass word offered in the final bit cycle");
    applyStimulus(0, 8'h5A);
    waitNeg(7);
    applyStimulus(0, 8'hE7);
    checkOutput("bypass busy", busy[0], 1'b1);
    checkOutput("bypass bit0", serialOut[0], 1'b1);
    checkOutput("bypass hold empty", txReady[0], 1'b1);
    waitDrain(0);

    $display("[TB] reset in the middle of a frame");
    applyStimulus(0, 8'h96);
    waitNeg(3);
    resetN = 1'b0;
    #1;
    checkOutput("midreset ready", txReady[0], 1'b1);
    checkOutput("midreset outputs", {serialOut[0], shiftMode[0], frameDone[0], busy[0]}, 0);
    expQ0.delete();
    waitNeg(2);
    resetN = 1'b1;
    waitNeg(1);
    applyStimulus(0, 8'hFF);
    waitDrain(0);

    $display("[TB] valid pulsed while the hold register is full");
    applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22);
    checkOutput("backpressure ready", txReady[0], 1'b0);
    txValid[0] = 1'b1;
    txData[0]  = 8'h99;
    waitNeg(1);
    txValid[0] = 1'b0;
    checkOutput("backpressure still full", txReady[0], 1'b0);
    waitDrain(0);

    $display("[TB] random traffic");
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++) begin
        applyStimulus(u, 8'($urandom));
        if ($urandom_range(0, 2) == 0) waitNeg($urandom_range(0, 10 * divOf(u)));
      end
      waitDrain(u);
    end

    waitNeg(2);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
